// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one block-wide memory port between the I-cache
// fill path and the D-cache fill/write-back path, with a per-transfer timeout.
module cache_mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_read_m,
  input  logic [WORD_SIZE-1:0]   i_address,
  output logic [4*WORD_SIZE-1:0] i_data,
  output logic                   i_inputReady,
  input  logic                   d_read_m,
  input  logic                   d_write_m,
  input  logic [WORD_SIZE-1:0]   d_address,
  input  logic [4*WORD_SIZE-1:0] d_wdata,
  output logic [4*WORD_SIZE-1:0] d_data,
  output logic                   d_inputReady,
  output logic                   d_ackOutput,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [WORD_SIZE-1:0]   mem_address,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  input  logic                   mem_inputReady,
  input  logic                   mem_ackOutput,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int BW = 4 * WORD_SIZE;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_I_XFER = 2'd1;
  localparam logic [1:0] S_D_XFER = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic                 last_d_q, last_d_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [BW-1:0]        wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic [7:0]           wait_q, wait_d;
  logic                 to_q, to_d;
  logic [BW-1:0]        i_data_q, i_data_d;
  logic [BW-1:0]        d_data_q, d_data_d;
  logic                 i_rdy_q, i_rdy_d;
  logic                 d_rdy_q, d_rdy_d;
  logic                 d_ack_q, d_ack_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 busy_q, busy_d;

  logic d_req_s;
  logic pick_d_s;
  logic done_s;
  logic finish_s;
  logic unused_s;

  assign d_req_s  = d_read_m | d_write_m;
  assign unused_s = ^{i_address[1:0], d_address[1:0]};

  // Next-state: grant selection in IDLE, completion/timeout tracking in XFER.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    wait_d   = wait_q;
    to_d     = to_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    i_rdy_d  = 1'b0;
    d_rdy_d  = 1'b0;
    d_ack_d  = 1'b0;
    pick_d_s = 1'b0;
    done_s   = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        // With both sides pending, the side not served last wins.
        pick_d_s = d_req_s && (!i_read_m || !last_d_q);
        if (i_read_m || d_req_s) begin
          last_d_d = pick_d_s;
          wait_d   = 8'd0;
          if (pick_d_s) begin
            addr_d   = {d_address[WORD_SIZE-1:2], 2'b00};
            wr_d     = d_write_m;
            wdata_d  = d_write_m ? d_wdata : wdata_q;
            mem_rd_d = ~d_write_m;
            mem_wr_d = d_write_m;
            state_d  = S_D_XFER;
          end else begin
            addr_d   = {i_address[WORD_SIZE-1:2], 2'b00};
            wr_d     = 1'b0;
            mem_rd_d = 1'b1;
            mem_wr_d = 1'b0;
            state_d  = S_I_XFER;
          end
        end else begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end
      end
      S_I_XFER, S_D_XFER: begin
        done_s = wr_q ? mem_ackOutput : mem_inputReady;
        if (done_s) begin
          finish_s = 1'b1;
          i_data_d = (!wr_q && !last_d_q) ? mem_rdata : i_data_q;
          d_data_d = (!wr_q &&  last_d_q) ? mem_rdata : d_data_q;
        end else if (wait_q == WAIT_LAST) begin
          // Release the cache with an empty block rather than hang it.
          finish_s = 1'b1;
          to_d     = 1'b1;
          i_data_d = (!wr_q && !last_d_q) ? {BW{1'b0}} : i_data_q;
          d_data_d = (!wr_q &&  last_d_q) ? {BW{1'b0}} : d_data_q;
        end else begin
          wait_d = wait_q + 8'd1;
        end
        if (finish_s) begin
          state_d  = S_RESP;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          d_ack_d  = wr_q;
          d_rdy_d  = !wr_q && last_d_q;
          i_rdy_d  = !wr_q && !last_d_q;
        end else begin
          state_d = state_q;
        end
      end
      S_RESP: begin
        state_d  = S_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      last_d_q <= 1'b0;
      addr_q   <= {WORD_SIZE{1'b0}};
      wdata_q  <= {BW{1'b0}};
      wr_q     <= 1'b0;
      wait_q   <= 8'd0;
      to_q     <= 1'b0;
      i_data_q <= {BW{1'b0}};
      d_data_q <= {BW{1'b0}};
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      wait_q   <= wait_d;
      to_q     <= to_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
      i_rdy_q  <= i_rdy_d;
      d_rdy_q  <= d_rdy_d;
      d_ack_q  <= d_ack_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      busy_q   <= busy_d;
    end
  end

  assign i_data       = i_data_q;
  assign i_inputReady = i_rdy_q;
  assign d_data       = d_data_q;
  assign d_inputReady = d_rdy_q;
  assign d_ackOutput  = d_ack_q;
  assign mem_read     = mem_rd_q;
  assign mem_write    = mem_wr_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = busy_q;
  assign timeout_err  = to_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: random requesters, a memory model
// that predicts grants by round-robin rules, and a decoupled response monitor.
module tb_cache_mem_arbiter;

  localparam int WS = 16;
  localparam int BW = 64;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_read_m;
  logic [WS-1:0] i_address;
  logic [BW-1:0] i_data;
  logic          i_inputReady;
  logic          d_read_m;
  logic          d_write_m;
  logic [WS-1:0] d_address;
  logic [BW-1:0] d_wdata;
  logic [BW-1:0] d_data;
  logic          d_inputReady;
  logic          d_ackOutput;
  logic          mem_read;
  logic          mem_write;
  logic [WS-1:0] mem_address;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata;
  logic          mem_inputReady;
  logic          mem_ackOutput;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.WORD_SIZE(WS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read_m(i_read_m), .i_address(i_address), .i_data(i_data), .i_inputReady(i_inputReady),
    .d_read_m(d_read_m), .d_write_m(d_write_m), .d_address(d_address), .d_wdata(d_wdata),
    .d_data(d_data), .d_inputReady(d_inputReady), .d_ackOutput(d_ackOutput),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_inputReady(mem_inputReady),
    .mem_ackOutput(mem_ackOutput), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    int            kind;   // 0 I fill, 1 D fill, 2 D write-back ack
    logic [BW-1:0] data;
    bit            to;
  } exp_t;

  int      checks = 0;
  int      errors = 0;
  exp_t    exp_q[$];
  bit      grant_log[$];
  bit      model_last_d = 1'b0;
  bit      model_to = 1'b0;
  logic [BW-1:0] model_d_data = 64'd0;
  int      force_lat = 0;
  bit      force_data_en = 1'b0;
  logic [BW-1:0] force_data = 64'd0;
  bit      hang = 1'b0;
  bit      rst_mode = 1'b0;

  bit            prev_cmd = 1'b0;
  bit            s_i = 1'b0, s_rd = 1'b0, s_wr = 1'b0;
  logic [WS-1:0] s_ia = 16'd0, s_da = 16'd0;
  logic [BW-1:0] s_wd = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: predicts the grant from the rules, checks the command, then responds.
  task automatic serve(input bit si, input bit srd, input bit swr,
                       input logic [WS-1:0] sia, input logic [WS-1:0] sda,
                       input logic [BW-1:0] swd);
    bit sd, ewr, hung, rm;
    logic [WS-1:0] ea;
    logic [BW-1:0] rd;
    logic [1:0] cmd_exp;
    int lat;
    exp_t e;
    if (!si && !(srd || swr)) chk("cmd_without_request", 64'd1, 64'd0);
    sd = (srd || swr) && (!si || !model_last_d);
    model_last_d = sd;
    grant_log.push_back(sd);
    ea = sd ? {sda[15:2], 2'b00} : {sia[15:2], 2'b00};
    ewr = sd && swr;
    cmd_exp = ewr ? 2'b01 : 2'b10;
    chk("cmd_addr", mem_address, ea);
    chk("cmd_rw", {mem_read, mem_write}, cmd_exp);
    if (ewr) chk("cmd_wdata", mem_wdata, swd);
    chk("busy_in_xfer", busy, 1'b1);
    rm = rst_mode;
    hung = hang;
    hang = 1'b0;
    if (rm) begin
      rst_mode = 1'b0;
      for (int t = 0; t < 4 * TO && (mem_read || mem_write); t++) @(negedge clk);
      return;
    end
    lat = (force_lat != 0) ? force_lat : $urandom_range(1, TO - 2);
    rd = force_data_en ? force_data : {$urandom, $urandom};
    if (hung) lat = TO;
    model_to = model_to | hung;
    e.kind = ewr ? 2 : (sd ? 1 : 0);
    e.data = hung ? 64'd0 : rd;
    e.to = model_to;
    exp_q.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      chk("cmd_held_rw", {mem_read, mem_write}, cmd_exp);
      chk("cmd_held_addr", mem_address, ea);
      if (k == lat && !hung) begin
        if (ewr) mem_ackOutput = 1'b1;
        else begin
          mem_inputReady = 1'b1;
          mem_rdata = rd;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        if (ewr) begin
          mem_inputReady = 1'b1;
          mem_rdata = {$urandom, $urandom};
        end else mem_ackOutput = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_inputReady = 1'b0;
      mem_ackOutput = 1'b0;
      mem_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    chk("cmd_dropped", {mem_read, mem_write}, 2'b00);
  endtask

  initial begin : mem_side
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && (mem_read === 1'b1 || mem_write === 1'b1) && !prev_cmd)
        serve(s_i, s_rd, s_wr, s_ia, s_da, s_wd);
      prev_cmd = (mem_read === 1'b1 || mem_write === 1'b1);
      s_i = i_read_m; s_rd = d_read_m; s_wr = d_write_m;
      s_ia = i_address; s_da = d_address; s_wd = d_wdata;
    end
  end

  initial begin : resp_monitor
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && (i_inputReady === 1'b1 || d_inputReady === 1'b1 || d_ackOutput === 1'b1)) begin
        int act;
        exp_t e;
        chk("pulse_onehot", int'(i_inputReady) + int'(d_inputReady) + int'(d_ackOutput), 64'd1);
        act = i_inputReady ? 0 : (d_inputReady ? 1 : 2);
        if (exp_q.size() == 0) chk("unexpected_pulse", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("pulse_kind", act, e.kind);
          if (e.kind == 0) chk("i_data", i_data, e.data);
          else if (e.kind == 1) begin
            chk("d_data", d_data, e.data);
            model_d_data = e.data;
          end else chk("d_data_kept", d_data, model_d_data);
          chk("timeout_err_at_pulse", timeout_err, e.to);
        end
      end
    end
  end

  task automatic i_req(input logic [WS-1:0] a, input int gap);
    bit got = 1'b0;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    i_address = a;
    i_read_m = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (i_inputReady === 1'b1) got = 1'b1;
      else begin
        @(posedge clk); #1;
        if ($urandom_range(0, 3) == 0) i_address = 16'($urandom);
      end
    end
    if (!got) chk("i_req_no_ready", 64'd0, 64'd1);
    @(posedge clk); #1;
    i_read_m = 1'b0;
  endtask

  task automatic d_req(input bit wr, input logic [WS-1:0] a, input logic [BW-1:0] wd, input int gap);
    bit got = 1'b0;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    d_address = a;
    d_wdata = wd;
    d_write_m = wr;
    d_read_m = ~wr;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if ((wr && d_ackOutput === 1'b1) || (!wr && d_inputReady === 1'b1)) got = 1'b1;
      else begin
        @(posedge clk); #1;
        if ($urandom_range(0, 3) == 0) d_address = 16'($urandom);
      end
    end
    if (!got) chk("d_req_no_ready", 64'd0, 64'd1);
    @(posedge clk); #1;
    d_read_m = 1'b0;
    d_write_m = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int s;
    reset_n = 1'b0;
    i_read_m = 1'b0; i_address = 16'd0;
    d_read_m = 1'b0; d_write_m = 1'b0; d_address = 16'd0; d_wdata = 64'd0;
    mem_rdata = 64'd0; mem_inputReady = 1'b0; mem_ackOutput = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    chk("rst_mem_addr", mem_address, 16'd0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_i_data", i_data, 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    chk("rst_pulses", {i_inputReady, d_inputReady, d_ackOutput}, 3'b000);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Simultaneous requests straight after reset: D first, then I.
    s = grant_log.size();
    fork
      i_req(16'h0100, 0);
      d_req(1'b0, 16'h0204, 64'd0, 0);
    join
    chk("simul_count", grant_log.size() - s, 64'd2);
    if (grant_log.size() >= s + 2) begin
      chk("simul_first_d", grant_log[s], 1'b1);
      chk("simul_second_i", grant_log[s + 1], 1'b0);
    end

    // Single I fill with a fixed three-cycle memory latency.
    force_lat = 3; force_data_en = 1'b1; force_data = 64'h4444_3333_2222_1111;
    i_req(16'h0123, 0);
    force_lat = 0; force_data_en = 1'b0;
    @(negedge clk);
    chk("fill_busy_drop", busy, 1'b0);
    chk("fill_i_data_hold", i_data, 64'h4444_3333_2222_1111);

    // Write-back then fill on the D side.
    force_lat = 2;
    d_req(1'b1, 16'h0208, {4{16'hAAAA}}, 0);
    force_lat = 0;
    d_req(1'b0, 16'h0310, 64'd0, 0);

    // Fairness: both sides continuously requesting alternate strictly.
    s = grant_log.size();
    fork
      for (int n = 0; n < 10; n++) i_req(16'($urandom), 0);
      for (int n = 0; n < 10; n++) d_req(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom}, 0);
    join
    chk("fair_count", grant_log.size() - s, 64'd20);
    for (int n = s + 1; n < grant_log.size(); n++)
      chk("fair_alternate", grant_log[n], !grant_log[n - 1]);

    // Random traffic with random gaps and latencies.
    fork
      for (int n = 0; n < 25; n++) i_req(16'($urandom), $urandom_range(0, 4));
      for (int n = 0; n < 25; n++) d_req(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom}, $urandom_range(0, 4));
    join

    // Timeout: memory never completes.
    hang = 1'b1;
    i_req(16'h0777, 0);
    @(negedge clk);
    chk("timeout_sticky", timeout_err, 1'b1);
    chk("timeout_mem_idle", {mem_read, mem_write}, 2'b00);

    // Reset in the middle of a D transfer.
    rst_mode = 1'b1;
    @(posedge clk); #1;
    d_address = 16'h0450;
    d_read_m = 1'b1;
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        if (mem_read === 1'b1) seen = 1'b1;
      end
      chk("rst_xfer_cmd_seen", seen, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    d_read_m = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_last_d = 1'b0;
    model_to = 1'b0;
    model_d_data = 64'd0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_xfer_mem_read", mem_read, 1'b0);
    chk("rst_xfer_busy", busy, 1'b0);
    chk("rst_xfer_timeout", timeout_err, 1'b0);
    chk("rst_xfer_no_pulse", d_inputReady, 1'b0);
    repeat (2 * TO) @(negedge clk);

    // After reset the round-robin pointer is back on I.
    s = grant_log.size();
    fork
      i_req(16'h0a00, 0);
      d_req(1'b1, 16'h0b00, 64'h0123_4567_89ab_cdef, 0);
    join
    if (grant_log.size() >= s + 2) begin
      chk("post_rst_first_d", grant_log[s], 1'b1);
      chk("post_rst_second_i", grant_log[s + 1], 1'b0);
    end else chk("post_rst_count", grant_log.size() - s, 64'd2);
    @(negedge clk);
    chk("final_exp_empty", exp_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
